// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART with a TX FIFO, a programmable baud divisor
// and a level interrupt.
// Optional RX path (synchroniser, RX FIFO, sticky error flags) is built only
// when the macro UART_MMIO_RX_EN is defined.
// Register map: 0 DATA, 1 STATUS, 2 DIV, 3 IRQ_EN.
module uart_mmio #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD_RATE   = 1000000,
  parameter int TX_DEPTH    = 16,
  parameter int RX_DEPTH    = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        io_sel,
  input  logic [1:0]  reg_addr,
  input  logic        mem_rstrb,
  input  logic [3:0]  mem_wmask,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  input  logic        rxd,
  output logic        txd,
  output logic        irq
);

  localparam int          TX_AW     = $clog2(TX_DEPTH);
  localparam logic [15:0] DIV_RESET = 16'(CLK_FREQ_HZ / BAUD_RATE);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // Bus decode
  logic wr, rd, wr_data, wr_status;
  assign wr        = io_sel & (|mem_wmask);
  assign rd        = io_sel & mem_rstrb;
  assign wr_data   = wr & (reg_addr == 2'd0) & mem_wmask[0];
  assign wr_status = wr & (reg_addr == 2'd1);

  // Control/status registers
  logic [15:0] div_q, div_d;
  logic [2:0]  irq_en_q, irq_en_d;
  logic        tx_ovf_q, tx_ovf_d;
  logic        irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d;
  logic        txd_q, txd_d;

  // TX FIFO and shifter state
  logic [7:0]     tx_mem_q [TX_DEPTH];
  logic [TX_AW:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d, tx_count;
  logic           tx_full, tx_fifo_empty, tx_push, tx_drop, tx_pop;
  logic [7:0]     tx_head;
  tx_state_t      tx_state_q, tx_state_d;
  logic [15:0]    tx_cnt_q, tx_cnt_d;
  logic [2:0]     tx_bit_q, tx_bit_d;
  logic [7:0]     tx_shift_q, tx_shift_d;
  logic           tx_active, tx_empty;

  // RX-side values seen by the register file (constants without the RX path)
  logic        rx_valid, rx_full, rx_ovr, frame_err;
  logic [7:0]  rx_count8;
  logic [31:0] data_rd_val;

  assign tx_count      = tx_wptr_q - tx_rptr_q;
  assign tx_full       = (tx_count == (TX_AW+1)'(TX_DEPTH));
  assign tx_fifo_empty = (tx_count == '0);
  assign tx_push       = wr_data & ~tx_full;
  assign tx_drop       = wr_data & tx_full;
  assign tx_head       = tx_mem_q[tx_rptr_q[TX_AW-1:0]];
  assign tx_active     = (tx_state_q != TX_IDLE);
  assign tx_empty      = tx_fifo_empty & ~tx_active;

  logic [31:0] status;
  assign status = {rx_count8, 8'(tx_count), 6'b0, tx_full, tx_active, 1'b0,
                   tx_ovf_q, frame_err, rx_ovr, rx_full, rx_valid, tx_full, tx_empty};

  // Register writes, read data capture, sticky TX overflow and interrupt level
  always_comb begin
    div_d    = div_q;
    irq_en_d = irq_en_q;
    rdata_d  = rdata_q;
    if (wr && reg_addr == 2'd2) div_d = (mem_wdata[15:0] < 16'd4) ? 16'd4 : mem_wdata[15:0];
    if (wr && reg_addr == 2'd3) irq_en_d = mem_wdata[2:0];
    tx_ovf_d = (tx_ovf_q & ~(wr_status & mem_wdata[6])) | tx_drop;
    if (rd) begin
      case (reg_addr)
        2'd0:    rdata_d = data_rd_val;
        2'd1:    rdata_d = status;
        2'd2:    rdata_d = {16'b0, div_q};
        default: rdata_d = {29'b0, irq_en_q};
      endcase
    end
    irq_d = |(irq_en_q & {tx_ovf_q | rx_ovr | frame_err, tx_empty, rx_valid});
  end

  // TX pointers advance by one on push/pop; a dropped push leaves them alone
  always_comb begin
    tx_wptr_d = tx_wptr_q + {{TX_AW{1'b0}}, tx_push};
    tx_rptr_d = tx_rptr_q + {{TX_AW{1'b0}}, tx_pop};
  end

  // TX framing FSM: next state, baud countdown, bit index and line level
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    txd_d      = 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        if (!tx_fifo_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_cnt_d   = div_q - 16'd1;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        txd_d = 1'b0;
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d   = div_q - 16'd1;
          tx_bit_d   = 3'd0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      TX_DATA: begin
        txd_d = tx_shift_q[tx_bit_q];
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d = div_q - 16'd1;
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      default: begin
        if (tx_cnt_q == 16'd0) begin
          if (!tx_fifo_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
            tx_cnt_d   = div_q - 16'd1;
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
    endcase
  end

  // TX FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q[TX_AW-1:0]] <= mem_wdata[7:0];
  end

  // Register file, TX state and outputs; reset idles the line immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q      <= DIV_RESET;
      irq_en_q   <= 3'b0;
      tx_ovf_q   <= 1'b0;
      irq_q      <= 1'b0;
      rdata_q    <= 32'b0;
      txd_q      <= 1'b1;
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= 16'b0;
      tx_bit_q   <= 3'b0;
      tx_shift_q <= 8'b0;
    end else begin
      div_q      <= div_d;
      irq_en_q   <= irq_en_d;
      tx_ovf_q   <= tx_ovf_d;
      irq_q      <= irq_d;
      rdata_q    <= rdata_d;
      txd_q      <= txd_d;
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  assign mem_rdata = rdata_q;
  assign txd       = txd_q;
  assign irq       = irq_q;

  logic unused_wdata;
  assign unused_wdata = ^mem_wdata[31:16];

`ifdef UART_MMIO_RX_EN
  localparam int RX_AW = $clog2(RX_DEPTH);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic           rxd_s1_q, rxd_s2_q, rxd_prev_q;
  rx_state_t      rx_state_q, rx_state_d;
  logic [15:0]    rx_cnt_q, rx_cnt_d;
  logic [2:0]     rx_bit_q, rx_bit_d;
  logic [7:0]     rx_shift_q, rx_shift_d;
  logic [7:0]     rx_mem_q [RX_DEPTH];
  logic [RX_AW:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d, rx_count;
  logic           rx_push_req, rx_push, rx_pop, frame_set;
  logic           rx_ovr_q, rx_ovr_d, frame_err_q, frame_err_d;

  assign rx_count    = rx_wptr_q - rx_rptr_q;
  assign rx_valid    = (rx_count != '0);
  assign rx_full     = (rx_count == (RX_AW+1)'(RX_DEPTH));
  assign rx_count8   = 8'(rx_count);
  assign rx_ovr      = rx_ovr_q;
  assign frame_err   = frame_err_q;
  assign rx_pop      = rd & (reg_addr == 2'd0) & rx_valid;
  assign rx_push     = rx_push_req & ~rx_full;
  assign data_rd_val = rx_valid ? {24'b0, rx_mem_q[rx_rptr_q[RX_AW-1:0]]} : 32'h8000_0000;

  // RX framing FSM: start detect, mid-bit sampling, stop-bit verdict
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_push_req = 1'b0;
    frame_set   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rxd_prev_q && !rxd_s2_q) begin
          rx_cnt_d   = {1'b0, div_q[15:1]} - 16'd1;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == 16'd0) begin
          if (!rxd_s2_q) begin
            rx_cnt_d   = div_q - 16'd1;
            rx_bit_d   = 3'd0;
            rx_state_d = RX_DATA;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == 16'd0) begin
          rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
          rx_cnt_d   = div_q - 16'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      default: begin
        if (rx_cnt_q == 16'd0) begin
          rx_push_req = rxd_s2_q;
          frame_set   = ~rxd_s2_q;
          rx_state_d  = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
    endcase
  end

  // RX pointers and sticky flags; a set in the same cycle beats a W1C clear
  always_comb begin
    rx_wptr_d   = rx_wptr_q + {{RX_AW{1'b0}}, rx_push};
    rx_rptr_d   = rx_rptr_q + {{RX_AW{1'b0}}, rx_pop};
    rx_ovr_d    = (rx_ovr_q & ~(wr_status & mem_wdata[4])) | (rx_push_req & rx_full);
    frame_err_d = (frame_err_q & ~(wr_status & mem_wdata[5])) | frame_set;
  end

  // RX FIFO storage, written with the completed shift register
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wptr_q[RX_AW-1:0]] <= rx_shift_q;
  end

  // Synchroniser, RX state and flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_s1_q    <= 1'b1;
      rxd_s2_q    <= 1'b1;
      rxd_prev_q  <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= 16'b0;
      rx_bit_q    <= 3'b0;
      rx_shift_q  <= 8'b0;
      rx_wptr_q   <= '0;
      rx_rptr_q   <= '0;
      rx_ovr_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rxd_s1_q    <= rxd;
      rxd_s2_q    <= rxd_s1_q;
      rxd_prev_q  <= rxd_s2_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_wptr_q   <= rx_wptr_d;
      rx_rptr_q   <= rx_rptr_d;
      rx_ovr_q    <= rx_ovr_d;
      frame_err_q <= frame_err_d;
    end
  end
`else
  assign rx_valid    = 1'b0;
  assign rx_full     = 1'b0;
  assign rx_ovr      = 1'b0;
  assign frame_err   = 1'b0;
  assign rx_count8   = 8'd0;
  assign data_rd_val = 32'h8000_0000;

  logic unused_rx;
  assign unused_rx = ^{rxd, mem_wdata[5:4]};
`endif

endmodule

// File: tb/tb_uart_mmio.sv
// Directed self-checking bench for uart_mmio (default parameters, DIV=4 traffic).
module tb_uart_mmio;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        io_sel = 1'b0;
  logic [1:0]  reg_addr = 2'd0;
  logic        mem_rstrb = 1'b0;
  logic [3:0]  mem_wmask = 4'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [31:0] mem_rdata;
  logic        rxd, txd, irq;
  logic        rx_loop = 1'b0;
  logic        rxd_drv = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0, t, f, b;
  logic [31:0] rd;
  logic [9:0]  frame;
  logic [7:0]  byte_val;
  logic        exp_bit;

  assign rxd = rx_loop ? txd : rxd_drv;

  always #5 clk = ~clk;

  // Free-running edge counter used to time the serial line
  always @(posedge clk) cyc <= cyc + 1;

  uart_mmio dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .io_sel    (io_sel),
    .reg_addr  (reg_addr),
    .mem_rstrb (mem_rstrb),
    .mem_wmask (mem_wmask),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .rxd       (rxd),
    .txd       (txd),
    .irq       (irq)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single bus write; returns at the falling edge after the write edge
  task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    io_sel = 1'b1; reg_addr = addr; mem_wmask = 4'hF; mem_wdata = data;
    @(negedge clk);
    io_sel = 1'b0; mem_wmask = 4'h0;
  endtask

  // Single bus read; data is captured the cycle after the strobe edge
  task automatic busRead(input logic [1:0] addr, output logic [31:0] data);
    @(negedge clk);
    io_sel = 1'b1; reg_addr = addr; mem_rstrb = 1'b1;
    @(negedge clk);
    io_sel = 1'b0; mem_rstrb = 1'b0;
    data = mem_rdata;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_txd", {31'b0, txd}, 32'd1);
    checkOutput("reset_irq", {31'b0, irq}, 32'd0);
    checkOutput("reset_rdata", mem_rdata, 32'h0);
    reset_n = 1'b1;
    busRead(2'd1, rd); checkOutput("reset_status", rd, 32'h0000_0001);
    busRead(2'd2, rd); checkOutput("reset_div", rd, 32'd100);
    busRead(2'd3, rd); checkOutput("reset_irq_en", rd, 32'd0);
    busRead(2'd0, rd); checkOutput("data_empty", rd, 32'h8000_0000);

    // Divisor clamp, then DIV=4 for all traffic
    applyStimulus(2'd2, 32'd2);
    busRead(2'd2, rd); checkOutput("div_clamp", rd, 32'd4);
    applyStimulus(2'd2, 32'd4);
    busRead(2'd2, rd); checkOutput("div_4", rd, 32'd4);

    // Single frame 8'h61, checked every clock
    applyStimulus(2'd0, 32'h61);
    frame = {1'b1, 8'h61, 1'b0};
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      exp_bit = (k < 2 || k > 41) ? 1'b1 : frame[(k-2)/4];
      checkOutput($sformatf("tx61_t%0d", k), {31'b0, txd}, {31'b0, exp_bit});
    end
    busRead(2'd1, rd); checkOutput("tx61_idle_status", rd, 32'h0000_0001);

    // 18 back-to-back writes: 16 queued after the first pop, 18th dropped
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      io_sel = 1'b1; reg_addr = 2'd0; mem_wmask = 4'h1; mem_wdata = 32'h30 + i;
      if (i == 0) c0 = cyc + 1;
    end
    @(negedge clk);
    io_sel = 1'b0; mem_wmask = 4'h0;
    busRead(2'd1, rd); checkOutput("full_status", rd, 32'h0010_0342);
    while (cyc - c0 < 700) begin
      @(negedge clk);
      t = cyc - c0;
      if (t < 2 || t >= 682) exp_bit = 1'b1;
      else begin
        f = (t - 2) / 40;
        b = ((t - 2) % 40) / 4;
        byte_val = 8'h30 + 8'(f);
        exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : byte_val[b-1];
      end
      checkOutput($sformatf("b2b_t%0d", t), {31'b0, txd}, {31'b0, exp_bit});
    end
    busRead(2'd1, rd); checkOutput("ovf_sticky", rd, 32'h0000_0041);
    applyStimulus(2'd1, 32'h40);
    busRead(2'd1, rd); checkOutput("ovf_cleared", rd, 32'h0000_0001);

    // tx_empty interrupt
    applyStimulus(2'd3, 32'd2);
    @(negedge clk);
    checkOutput("irq_idle", {31'b0, irq}, 32'd1);
    applyStimulus(2'd0, 32'h55);
    busRead(2'd1, rd); checkOutput("irq_busy_status", rd, 32'h0000_0100);
    checkOutput("irq_busy", {31'b0, irq}, 32'd0);
    repeat (39) @(negedge clk);
    checkOutput("irq_last_stop", {31'b0, irq}, 32'd0);
    @(negedge clk);
    checkOutput("irq_drained", {31'b0, irq}, 32'd1);

    // Reset in the middle of a data bit
    applyStimulus(2'd0, 32'h00);
    applyStimulus(2'd0, 32'h00);
    repeat (6) @(negedge clk);
    checkOutput("pre_reset_txd", {31'b0, txd}, 32'd0);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_reset_txd", {31'b0, txd}, 32'd1);
    checkOutput("async_reset_irq", {31'b0, irq}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    busRead(2'd1, rd); checkOutput("post_reset_status", rd, 32'h0000_0001);
    busRead(2'd2, rd); checkOutput("post_reset_div", rd, 32'd100);

`ifdef UART_MMIO_RX_EN
    // Loopback receive of 8'hA5
    applyStimulus(2'd2, 32'd4);
    rx_loop = 1'b1;
    applyStimulus(2'd0, 32'hA5);
    repeat (60) @(negedge clk);
    busRead(2'd0, rd); checkOutput("rx_a5", rd, 32'h0000_00A5);
    busRead(2'd0, rd); checkOutput("rx_empty", rd, 32'h8000_0000);

    // Frame with a low stop bit
    rx_loop = 1'b0;
    frame = {1'b0, 8'h3C, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_drv = frame[i];
      repeat (4) @(negedge clk);
    end
    rxd_drv = 1'b1;
    repeat (20) @(negedge clk);
    busRead(2'd1, rd); checkOutput("rx_frame_err", rd, 32'h0000_0021);

    // 17 bytes without reading: 16 stored, one overrun
    applyStimulus(2'd1, 32'h20);
    rx_loop = 1'b1;
    for (int i = 0; i < 17; i++) applyStimulus(2'd0, 32'h10 + i);
    repeat (17 * 40 + 60) @(negedge clk);
    busRead(2'd1, rd); checkOutput("rx_overrun", rd, 32'h1000_001D);
    rx_loop = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
